regfile_wb_ctrl: RTL and testbench
==================================

// Module: regfile_wb_ctrl
// PURPOSE
//  Write-port controller and scoreboard for the 31x64b + XZR register file (1 write port, 2 read ports).
//  Shares the single write port between two writeback requesters: ALU/execute and load return.
//  Round-robin arbitration between the two requesters; registered write command.
//  Tracks destination registers with writes in flight and reports read-operand hazards to the decode stall logic.
// PARAMETERS
//  DATA_W    64  writeback data width
//  NREG      32  architectural register count (index width REG_W = 5)
//  ZERO_REG  31  hardwired-zero register index; never written, never pending
// PORTS
//  clk            in   1       single clock; all state updates on posedge
//  rst_n          in   1       asynchronous, active-low reset
//  issue_valid    in   1       decode issues an instr that will write issue_rd
//  issue_rd       in   5       destination of the issuing instruction
//  issue_ready    out  1       issue may proceed (no WAW on issue_rd)
//  rs1, rs2       in   5       read-operand indices being decoded
//  rs1_busy       out  1       rs1 has an unretired write (stall)
//  rs2_busy       out  1       rs2 has an unretired write (stall)
//  alu_valid      in   1       ALU writeback request
//  alu_rd         in   5       ALU writeback destination
//  alu_data       in   DATA_W  ALU writeback value
//  alu_ready      out  1       ALU request granted this cycle
//  ld_valid       in   1       load writeback request
//  ld_rd          in   5       load writeback destination
//  ld_data        in   DATA_W  load writeback value
//  ld_ready       out  1       load request granted this cycle
//  RegWrite       out  1       regfile write enable (registered)
//  WriteRegister  out  5       regfile write index (registered)
//  WriteData      out  DATA_W  regfile write data (registered)
//  pending        out  NREG    scoreboard bits (debug/visibility)
//  wb_err         out  1       sticky: writeback to a non-pending register
// BEHAVIOUR
//  Reset (async, immediate): RegWrite=0, WriteRegister=0, WriteData=0, pending=0, wb_err=0, last_grant=LD.
//  Arbitration:
//   - Combinational; at most one grant per cycle.
//   - One requester valid -> grant it.
//   - Both valid -> grant the requester not in last_grant.
//   - last_grant updates on every grant.
//   - *_ready = that requester's grant.
//   - Handshake completes when valid&&ready; requester holds rd/data stable while valid&&!ready.
//  Write command:
//   - Grant in cycle N -> RegWrite/WriteRegister/WriteData registered, driven during cycle N+1.
//   - Latency is 1 cycle; the regfile has no backpressure.
//   - No grant -> RegWrite=0 next cycle.
//  Zero register: a grant with rd==ZERO_REG completes the handshake but leaves RegWrite=0 and the scoreboard unchanged.
//  Scoreboard:
//   - Set: issue_valid&&issue_ready&&issue_rd!=ZERO_REG sets pending[issue_rd] at posedge.
//   - Clear: RegWrite clears pending[WriteRegister] at the posedge ending the RegWrite cycle.
//   - Same register set and cleared in one cycle -> set wins.
//  Busy:
//   - rsX_busy = pending[rsX] && !(RegWrite && WriteRegister==rsX).
//   - Bypass is legal because the regfile writes on the falling edge and reads combinationally.
//   - rsX==ZERO_REG -> busy=0.
//  issue_ready:
//   - = !pending[issue_rd] || (RegWrite && WriteRegister==issue_rd), or issue_rd==ZERO_REG.
//   - A writeback granted but not yet driven does not free the register.
//  Error: RegWrite to a register with pending==0 performs the write and sets wb_err; wb_err holds until reset.
//  Reset mid-operation: an in-flight write is dropped (RegWrite falls asynchronously); all pending bits are lost.
// STRUCTURE
//  Package regfile_ctrl_pkg:
//   - REG_W, DATA_W, NREG, ZERO_REG.
//   - typedef struct {logic valid; logic [REG_W-1:0] rd; logic [DATA_W-1:0] data;} wb_req_t.
//   - typedef enum logic {GNT_ALU, GNT_LD} gnt_t.
//  Sub-module rr_arb2: 2-way round-robin arbiter holding last_grant; async active-low reset.
//  Scoreboard and write register stay in regfile_wb_ctrl.
// TESTING
//  1 Reset: assert rst_n=0 during RegWrite=1 (WriteRegister=4).
//    -> RegWrite, pending and wb_err go to 0 without a clock edge.
//  2 Basic writeback: issue rd=3; rs1=3 -> busy=1.
//    ALU request X3=64'hDEAD_BEEF_0000_0001 granted in cycle N.
//    -> cycle N+1: RegWrite=1, WriteRegister=3, rs1_busy=0. Cycle N+2: pending[3]=0.
//  3 Contention after reset: alu rd=1 and ld rd=2 valid together.
//    -> alu_ready=1, ld_ready=0; next cycle ld granted.
//    Continuous dual requests -> grants alternate ALU, LD, ALU, ...
//  4 WAW: pending[5]=1, issue rd=5 -> issue_ready=0.
//    In the cycle RegWrite drives register 5 -> issue_ready=1; after the edge pending[5] stays 1.
//  5 Zero register: issue rd=31 -> issue_ready=1, pending unchanged.
//    ALU write rd=31 -> alu_ready=1, RegWrite stays 0.
//  6 Error: ld write rd=7 with pending[7]=0 -> RegWrite=1 to register 7 next cycle.
//    wb_err=1 and holds across later clean writes until rst_n=0.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file writeback controller.
package regfile_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 64;
  localparam int NREG   = 32;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

  // One writeback request as presented by a requester.
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Which requester won the most recent grant.
  typedef enum logic {GNT_ALU = 1'b0, GNT_LD = 1'b1} gnt_t;

  // True when the registered write command targets register idx this cycle.
  function automatic logic wb_hits(input logic we, input logic [REG_W-1:0] wr,
                                   input logic [REG_W-1:0] idx);
    return we && (wr == idx);
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bus bundle between decode/execute/load units and the writeback controller.
// Handshake: a writeback request transfers in the cycle where valid && ready
// are both high; while valid && !ready the requester holds rd and data stable.
// ready is a pure function of this cycle's valids and the arbiter state.
interface regfile_wb_ctrl_if;
  import regfile_ctrl_pkg::*;

  logic              issue_valid;
  logic [REG_W-1:0]  issue_rd;
  logic              issue_ready;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              alu_valid;
  logic [REG_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [REG_W-1:0]  ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              RegWrite;
  logic [REG_W-1:0]  WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [NREG-1:0]   pending;
  logic              wb_err;
  gnt_t              last_grant;

  modport master (
    output issue_valid, issue_rd, rs1, rs2,
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  issue_ready, rs1_busy, rs2_busy, alu_ready, ld_ready,
    input  RegWrite, WriteRegister, WriteData, pending, wb_err, last_grant
  );

  modport slave (
    input  issue_valid, issue_rd, rs1, rs2,
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output issue_ready, rs1_busy, rs2_busy, alu_ready, ld_ready,
    output RegWrite, WriteRegister, WriteData, pending, wb_err, last_grant
  );

endinterface

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter between ALU and load writeback requests.
module rr_arb2
  import regfile_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_alu,
  input  logic req_ld,
  output logic gnt_alu,
  output logic gnt_ld,
  output gnt_t last_grant
);

  gnt_t last_q, last_d;

  // Grant the lone requester, or on contention the one that did not win last.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_ld  = 1'b0;
    last_d  = last_q;
    if (req_alu && (!req_ld || last_q == GNT_LD)) begin
      gnt_alu = 1'b1;
      last_d  = GNT_ALU;
    end else if (req_ld) begin
      gnt_ld = 1'b1;
      last_d = GNT_LD;
    end
  end

  // Remember the last winner; after reset the ALU has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= GNT_LD;
    else        last_q <= last_d;
  end

  assign last_grant = last_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-port controller and pending-write scoreboard for the register file.
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  regfile_wb_ctrl_if.slave bus
);

  logic              gnt_alu, gnt_ld, issue_fire;
  wb_req_t           alu_req, ld_req, sel_req;
  logic              reg_write_q, reg_write_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              wb_err_q, wb_err_d;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_alu    (bus.alu_valid),
    .req_ld     (bus.ld_valid),
    .gnt_alu    (gnt_alu),
    .gnt_ld     (gnt_ld),
    .last_grant (bus.last_grant)
  );

  // Select the granted request; a grant to the zero register writes nothing.
  always_comb begin
    alu_req      = {bus.alu_valid, bus.alu_rd, bus.alu_data};
    ld_req       = {bus.ld_valid, bus.ld_rd, bus.ld_data};
    sel_req      = gnt_alu ? alu_req : ld_req;
    reg_write_d  = (gnt_alu || gnt_ld) && sel_req.valid && (sel_req.rd != ZERO_REG);
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (reg_write_d) begin
      write_reg_d  = sel_req.rd;
      write_data_d = sel_req.data;
    end
  end

  // Scoreboard update: retire the driven write first so a same-cycle issue wins.
  always_comb begin
    issue_fire = bus.issue_valid && bus.issue_ready && (bus.issue_rd != ZERO_REG);
    pending_d  = pending_q;
    if (reg_write_q) pending_d[write_reg_q] = 1'b0;
    if (issue_fire)  pending_d[bus.issue_rd] = 1'b1;
    wb_err_d = wb_err_q || (reg_write_q && !pending_q[write_reg_q]);
  end

  // Registered write command and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
      wb_err_q     <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
      wb_err_q     <= wb_err_d;
    end
  end

  // The regfile writes on the falling edge, so the write being driven now
  // already satisfies readers and a WAW issue to the same register.
  assign bus.rs1_busy    = (bus.rs1 != ZERO_REG) && pending_q[bus.rs1] &&
                           !wb_hits(reg_write_q, write_reg_q, bus.rs1);
  assign bus.rs2_busy    = (bus.rs2 != ZERO_REG) && pending_q[bus.rs2] &&
                           !wb_hits(reg_write_q, write_reg_q, bus.rs2);
  assign bus.issue_ready = (bus.issue_rd == ZERO_REG) || !pending_q[bus.issue_rd] ||
                           wb_hits(reg_write_q, write_reg_q, bus.issue_rd);

  assign bus.alu_ready     = gnt_alu;
  assign bus.ld_ready      = gnt_ld;
  assign bus.RegWrite      = reg_write_q;
  assign bus.WriteRegister = write_reg_q;
  assign bus.WriteData     = write_data_q;
  assign bus.pending       = pending_q;
  assign bus.wb_err        = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: arbitration table, scoreboard of write commands,
// and hand sequences for reset, bypass, WAW, zero register and error cases.
module tb_regfile_wb_ctrl;
  import regfile_ctrl_pkg::*;

  localparam int W = REG_W + DATA_W;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  logic [W-1:0] exp_q[$];

  regfile_wb_ctrl_if bus();

  regfile_wb_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              iv;
    logic [REG_W-1:0]  ird;
    logic              av;
    logic [REG_W-1:0]  ard;
    logic [DATA_W-1:0] ad;
    logic              lv;
    logic [REG_W-1:0]  lrd;
    logic [DATA_W-1:0] ldd;
    logic              exp_ga;
    logic              exp_gl;
    int                exp_ir;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: present one cycle of stimulus, check grants, queue expected writes.
  task automatic cyc(input logic iv, input logic [REG_W-1:0] ird,
                     input logic av, input logic [REG_W-1:0] ard, input logic [DATA_W-1:0] ad,
                     input logic lv, input logic [REG_W-1:0] lrd, input logic [DATA_W-1:0] ldd,
                     input logic exp_ga, input logic exp_gl, input int exp_ir);
    bus.issue_valid = iv;  bus.issue_rd = ird;
    bus.alu_valid   = av;  bus.alu_rd   = ard; bus.alu_data = ad;
    bus.ld_valid    = lv;  bus.ld_rd    = lrd; bus.ld_data  = ldd;
    #1;
    chk("alu_ready", W'(bus.alu_ready), W'(exp_ga));
    chk("ld_ready", W'(bus.ld_ready), W'(exp_gl));
    if (exp_ir >= 0) chk("issue_ready", W'(bus.issue_ready), W'(exp_ir));
    if (exp_ga && ard != ZERO_REG) exp_q.push_back({ard, ad});
    if (exp_gl && lrd != ZERO_REG) exp_q.push_back({lrd, ldd});
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b0;
    bus.ld_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard: every driven write command must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.RegWrite) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL wb_cmd: unexpected write reg=%0d data=%0h", bus.WriteRegister, bus.WriteData);
      end else begin
        chk("wb_cmd", {bus.WriteRegister, bus.WriteData}, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.rs1 = '0; bus.rs2 = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;

    // Arbitration table; grant expectations start from "ALU wins first".
    tbl[0] = '{1'b1, 5'd10, 1'b1, 5'd1, {$urandom, $urandom}, 1'b1, 5'd2, {$urandom, $urandom}, 1'b1, 1'b0, 1};
    tbl[1] = '{1'b0, 5'd0,  1'b1, 5'd3, {$urandom, $urandom}, 1'b1, 5'd2, tbl[0].ldd,           1'b0, 1'b1, -1};
    tbl[2] = '{1'b0, 5'd0,  1'b1, 5'd3, tbl[1].ad,            1'b1, 5'd5, {$urandom, $urandom}, 1'b1, 1'b0, -1};
    tbl[3] = '{1'b0, 5'd0,  1'b0, 5'd0, 64'd0,                1'b1, 5'd5, tbl[2].ldd,           1'b0, 1'b1, -1};
    tbl[4] = '{1'b0, 5'd0,  1'b1, 5'd6, {$urandom, $urandom}, 1'b0, 5'd0, 64'd0,                1'b1, 1'b0, -1};
    tbl[5] = '{1'b0, 5'd0,  1'b1, 5'd7, {$urandom, $urandom}, 1'b0, 5'd0, 64'd0,                1'b1, 1'b0, -1};
    tbl[6] = '{1'b0, 5'd0,  1'b1, 5'd8, {$urandom, $urandom}, 1'b1, 5'd9, {$urandom, $urandom}, 1'b0, 1'b1, -1};
    tbl[7] = '{1'b0, 5'd0,  1'b1, 5'd8, tbl[6].ad,            1'b1, 5'd4, {$urandom, $urandom}, 1'b1, 1'b0, -1};
    tbl[8] = '{1'b0, 5'd0,  1'b0, 5'd0, 64'd0,                1'b1, 5'd4, tbl[7].ldd,           1'b0, 1'b1, -1};

    // Reset state
    idle(2);
    chk("rst_RegWrite", W'(bus.RegWrite), W'(0));
    chk("rst_WriteRegister", W'(bus.WriteRegister), W'(0));
    chk("rst_WriteData", W'(bus.WriteData), W'(0));
    chk("rst_pending", W'(bus.pending), W'(0));
    chk("rst_wb_err", W'(bus.wb_err), W'(0));
    rst_n = 1'b1;
    idle(1);

    // Contention and alternation straight out of reset
    for (int i = 0; i < 9; i++)
      cyc(tbl[i].iv, tbl[i].ird, tbl[i].av, tbl[i].ard, tbl[i].ad,
          tbl[i].lv, tbl[i].lrd, tbl[i].ldd, tbl[i].exp_ga, tbl[i].exp_gl, tbl[i].exp_ir);
    chk("pre_rst_RegWrite", W'(bus.RegWrite), W'(1));
    chk("pre_rst_WriteRegister", W'(bus.WriteRegister), W'(4));
    chk("pre_rst_pending10", W'(bus.pending[10]), W'(1));
    chk("unpending_wb_err", W'(bus.wb_err), W'(1));

    // Asynchronous reset while a write is being driven
    rst_n = 1'b0;
    #1;
    chk("async_RegWrite", W'(bus.RegWrite), W'(0));
    chk("async_pending", W'(bus.pending), W'(0));
    chk("async_wb_err", W'(bus.wb_err), W'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Basic writeback with read bypass
    cyc(1'b1, 5'd3, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1);
    bus.rs1 = 5'd3;
    bus.rs2 = ZERO_REG;
    #1;
    chk("rs1_busy_set", W'(bus.rs1_busy), W'(1));
    chk("rs2_busy_zero", W'(bus.rs2_busy), W'(0));
    cyc(1'b0, 5'd0, 1'b1, 5'd3, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, -1);
    chk("basic_RegWrite", W'(bus.RegWrite), W'(1));
    chk("basic_WriteRegister", W'(bus.WriteRegister), W'(3));
    chk("rs1_bypass", W'(bus.rs1_busy), W'(0));
    idle(1);
    chk("basic_pending3", W'(bus.pending[3]), W'(0));
    chk("basic_idle_RegWrite", W'(bus.RegWrite), W'(0));

    // WAW on register 5; a granted but undriven write does not free it
    cyc(1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1);
    cyc(1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, {$urandom, $urandom}, 1'b0, 1'b1, 0);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd5;
    #1;
    chk("waw_ready_on_write", W'(bus.issue_ready), W'(1));
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    chk("waw_set_wins", W'(bus.pending[5]), W'(1));
    chk("waw_ready_after", W'(bus.issue_ready), W'(0));
    cyc(1'b0, 5'd0, 1'b1, 5'd5, {$urandom, $urandom}, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, -1);
    idle(1);
    chk("waw_cleared", W'(bus.pending), W'(0));
    chk("waw_no_err", W'(bus.wb_err), W'(0));

    // Zero register: issue and write are accepted but have no effect
    cyc(1'b1, ZERO_REG, 1'b1, ZERO_REG, {$urandom, $urandom}, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1);
    chk("zero_RegWrite", W'(bus.RegWrite), W'(0));
    chk("zero_pending", W'(bus.pending), W'(0));
    bus.rs1 = ZERO_REG;
    #1;
    chk("zero_rs1_busy", W'(bus.rs1_busy), W'(0));

    // Error: load write to a non-pending register still performs the write
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, {$urandom, $urandom}, 1'b0, 1'b1, -1);
    chk("err_RegWrite", W'(bus.RegWrite), W'(1));
    chk("err_WriteRegister", W'(bus.WriteRegister), W'(7));
    chk("err_not_yet", W'(bus.wb_err), W'(0));
    idle(1);
    chk("err_set", W'(bus.wb_err), W'(1));
    cyc(1'b1, 5'd12, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1);
    cyc(1'b0, 5'd0, 1'b1, 5'd12, {$urandom, $urandom}, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, -1);
    idle(1);
    chk("err_sticky", W'(bus.wb_err), W'(1));
    chk("err_pending", W'(bus.pending), W'(0));
    chk("sb_drained", W'(exp_q.size()), W'(0));
    rst_n = 1'b0;
    #1;
    chk("err_reset", W'(bus.wb_err), W'(0));
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
